// File: rtl/descrambler.sv
// Receive-side s^7+s^4+1 (802.11) AXI-Stream descrambler with per-packet LFSR acquisition.
// Optional seed_out/seed_valid observation ports are enabled by DESCRAMBLER_SEED_OUT_EN.

// state | meaning
// ACQ   | next accepted beat is a packet start (acquire or load SEED)
// RUN   | mid-packet, keystream continues from lfsr_q

module descrambler #(
    parameter int         WIDTH   = 32,
    parameter logic [6:0] SEED    = 7'b1111111,
    parameter bit         ACQUIRE = 1'b1
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [WIDTH-1:0] s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic             s_axis_tlast,
    output logic [WIDTH-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast,
    output logic             m_axis_tuser
`ifdef DESCRAMBLER_SEED_OUT_EN
    ,
    output logic [6:0]       seed_out,
    output logic             seed_valid
`endif
);

    typedef enum logic {
        ST_ACQ = 1'b0,
        ST_RUN = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             accept;
    logic             pkt_start;

    logic [6:0]       lfsr_q;
    logic [6:0]       ks_state;
    logic [6:0]       lfsr_post;
    logic             ks_bit;
    logic             acq_beat;
    logic [WIDTH-1:0] keystream;
    logic [WIDTH-1:0] beat_data;
    logic             beat_user;

    logic             skid_valid_q;
    logic [WIDTH-1:0] skid_data_q;
    logic             skid_last_q;
    logic             skid_user_q;

    logic             out_free;
    logic             load_out_skid;
    logic             load_out_beat;
    logic             load_skid;
    logic             skid_valid_d;
    logic             out_valid_d;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= ST_ACQ;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        accept    = s_axis_tvalid && s_axis_tready;
        pkt_start = accept && (state_q == ST_ACQ);
        case (state_q)
            ST_ACQ: if (accept && !s_axis_tlast) state_d = ST_RUN;
            ST_RUN: if (accept && s_axis_tlast)  state_d = ST_ACQ;
            default: state_d = ST_ACQ;
        endcase
    end

    // In acquisition the first 7 keystream bits are the received bits themselves,
    // so after 7 shifts the register holds the transmitter state regardless of the start.
    always_comb begin
        acq_beat  = ACQUIRE && (state_q == ST_ACQ);
        ks_state  = (state_q == ST_ACQ) ? SEED : lfsr_q;
        keystream = '0;
        ks_bit    = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (acq_beat && (i < 7)) begin
                ks_bit = s_axis_tdata[i];
            end else begin
                ks_bit = ks_state[3] ^ ks_state[0];
            end
            keystream[i] = ks_bit;
            ks_state     = {ks_bit, ks_state[6:1]};
        end
        lfsr_post = ks_state;
    end

    assign beat_data = s_axis_tdata ^ keystream;
    assign beat_user = acq_beat && (s_axis_tdata[6:0] == 7'h00);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            lfsr_q <= SEED;
        end else if (accept) begin
            lfsr_q <= lfsr_post;
        end
    end

    // Skid control: tready is simply "skid empty next cycle", so at most one
    // beat can land in the skid per stall.
    always_comb begin
        out_free      = !m_axis_tvalid || m_axis_tready;
        load_out_skid = out_free && skid_valid_q;
        load_out_beat = out_free && !skid_valid_q && accept;
        load_skid     = !out_free && accept;
        skid_valid_d  = skid_valid_q;
        if (load_out_skid) begin
            skid_valid_d = 1'b0;
        end else if (load_skid) begin
            skid_valid_d = 1'b1;
        end
        out_valid_d = out_free ? (skid_valid_q || accept) : 1'b1;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            s_axis_tready <= 1'b1;
            skid_valid_q  <= 1'b0;
            skid_data_q   <= '0;
            skid_last_q   <= 1'b0;
            skid_user_q   <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
        end else begin
            s_axis_tready <= !skid_valid_d;
            skid_valid_q  <= skid_valid_d;
            m_axis_tvalid <= out_valid_d;
            if (load_skid) begin
                skid_data_q <= beat_data;
                skid_last_q <= s_axis_tlast;
                skid_user_q <= beat_user;
            end
            if (load_out_skid) begin
                m_axis_tdata <= skid_data_q;
                m_axis_tlast <= skid_last_q;
                m_axis_tuser <= skid_user_q;
            end else if (load_out_beat) begin
                m_axis_tdata <= beat_data;
                m_axis_tlast <= s_axis_tlast;
                m_axis_tuser <= beat_user;
            end
        end
    end

`ifdef DESCRAMBLER_SEED_OUT_EN
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            seed_out   <= 7'h00;
            seed_valid <= 1'b0;
        end else begin
            seed_valid <= pkt_start;
            if (pkt_start) begin
                seed_out <= ACQUIRE ? s_axis_tdata[6:0] : SEED;
            end
        end
    end
`endif

endmodule

// File: tb/tb_descrambler.sv
// Directed self-checking bench for descrambler: acquisition, back-to-back, backpressure,
// locked seed, reset mid-packet, and an ACQUIRE=0 instance.

module tb_descrambler;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    always #5 aclk = ~aclk;

    logic [31:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        s_axis_tlast = 1'b0;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tlast;
    logic        m_axis_tuser;

    logic [31:0] s0_tdata = '0;
    logic        s0_tvalid = 1'b0;
    logic        s0_tready;
    logic        s0_tlast = 1'b0;
    logic [31:0] m0_tdata;
    logic        m0_tvalid;
    logic        m0_tready = 1'b1;
    logic        m0_tlast;
    logic        m0_tuser;

`ifdef DESCRAMBLER_SEED_OUT_EN
    logic [6:0]  seed_out;
    logic        seed_valid;
    logic [6:0]  seed_out0;
    logic        seed_valid0;
    int          seed_pulses = 0;
`endif

    descrambler #(.WIDTH(32), .SEED(7'h7F), .ACQUIRE(1'b1)) u_dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser)
`ifdef DESCRAMBLER_SEED_OUT_EN
        ,
        .seed_out      (seed_out),
        .seed_valid    (seed_valid)
`endif
    );

    descrambler #(.WIDTH(32), .SEED(7'h7F), .ACQUIRE(1'b0)) u_dut0 (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s0_tdata),
        .s_axis_tvalid (s0_tvalid),
        .s_axis_tready (s0_tready),
        .s_axis_tlast  (s0_tlast),
        .m_axis_tdata  (m0_tdata),
        .m_axis_tvalid (m0_tvalid),
        .m_axis_tready (m0_tready),
        .m_axis_tlast  (m0_tlast),
        .m_axis_tuser  (m0_tuser)
`ifdef DESCRAMBLER_SEED_OUT_EN
        ,
        .seed_out      (seed_out0),
        .seed_valid    (seed_valid0)
`endif
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] got_d[$];
    logic        got_l[$];
    logic        got_u[$];
    logic [31:0] exp_d[$];
    logic        exp_l[$];
    logic        exp_u[$];
    logic [31:0] pkt[$];
    bit          rand_rdy = 1'b0;
    logic        force_rdy = 1'b1;
    int          stab_err = 0;
    int          trdy_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Transmit-side scrambler: returns {post_state, scrambled_beat}.
    function automatic logic [38:0] scr(input logic [31:0] p, input logic [6:0] st);
        logic [6:0]  s;
        logic [31:0] o;
        logic        kb;
        s = st;
        o = '0;
        for (int i = 0; i < 32; i++) begin
            kb   = s[3] ^ s[0];
            o[i] = p[i] ^ kb;
            s    = {kb, s[6:1]};
        end
        return {s, o};
    endfunction

    initial begin
        forever begin
            @(posedge aclk);
            #2;
            m_axis_tready = rand_rdy ? 1'($urandom_range(0, 1)) : force_rdy;
        end
    end

    logic        prev_stall = 1'b0;
    logic        prev_rdy = 1'b0;
    logic [33:0] prev_beat = '0;
    initial begin
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                prev_stall = 1'b0;
                prev_rdy   = 1'b0;
            end else begin
                if (prev_stall && !(m_axis_tvalid &&
                    {m_axis_tdata, m_axis_tlast, m_axis_tuser} == prev_beat)) stab_err++;
                if (prev_rdy && !s_axis_tready) trdy_err++;
                if (m_axis_tvalid && m_axis_tready) begin
                    got_d.push_back(m_axis_tdata);
                    got_l.push_back(m_axis_tlast);
                    got_u.push_back(m_axis_tuser);
                end
                prev_stall = m_axis_tvalid && !m_axis_tready;
                prev_beat  = {m_axis_tdata, m_axis_tlast, m_axis_tuser};
                prev_rdy   = m_axis_tready;
            end
`ifdef DESCRAMBLER_SEED_OUT_EN
            if (seed_valid) seed_pulses++;
`endif
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_beat(input logic [31:0] d, input logic l);
        int n;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        n = 0;
        @(negedge aclk);
        while (!s_axis_tready && n < 500) begin
            n++;
            @(negedge aclk);
        end
        if (n >= 500) check("accept_timeout", 64'(n), 64'(0));
        @(posedge aclk);
        #1;
    endtask

    task automatic idle();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic send_pkt(input logic [6:0] seed, input bit chk_lat);
        logic [6:0]  st;
        logic [38:0] r;
        st = seed;
        for (int j = 0; j < pkt.size(); j++) begin
            r  = scr(pkt[j], st);
            st = r[38:32];
            exp_d.push_back(pkt[j]);
            exp_l.push_back(j == pkt.size() - 1);
            exp_u.push_back((j == 0) && (seed == 7'h00));
            send_beat(r[31:0], j == pkt.size() - 1);
            if (chk_lat && j == 0) begin
                check("latency_valid", 64'(m_axis_tvalid), 64'(1));
                check("latency_data", 64'(m_axis_tdata), 64'(pkt[0]));
            end
        end
    endtask

    task automatic drain_compare(input string tag);
        int n;
        n = 0;
        while (got_d.size() < exp_d.size() && n < 3000) begin
            @(posedge aclk);
            n++;
        end
        repeat (5) @(posedge aclk);
        #1;
        check({tag, "_count"}, 64'(got_d.size()), 64'(exp_d.size()));
        for (int i = 0; i < exp_d.size(); i++) begin
            if (i < got_d.size()) begin
                check($sformatf("%s_data%0d", tag, i), 64'(got_d[i]), 64'(exp_d[i]));
                check($sformatf("%s_last%0d", tag, i), 64'(got_l[i]), 64'(exp_l[i]));
                check($sformatf("%s_user%0d", tag, i), 64'(got_u[i]), 64'(exp_u[i]));
            end
        end
        got_d.delete(); got_l.delete(); got_u.delete();
        exp_d.delete(); exp_l.delete(); exp_u.delete();
    endtask

    task automatic d0_beat(input logic [31:0] d, input logic l, input logic [31:0] e,
                           input string tag);
        s0_tdata  = d;
        s0_tlast  = l;
        s0_tvalid = 1'b1;
        @(posedge aclk);
        #1;
        s0_tvalid = 1'b0;
        s0_tlast  = 1'b0;
        check({tag, "_valid"}, 64'(m0_tvalid), 64'(1));
        check({tag, "_data"}, 64'(m0_tdata), 64'(e));
        check({tag, "_last"}, 64'(m0_tlast), 64'(l));
        check({tag, "_user"}, 64'(m0_tuser), 64'(0));
    endtask

    initial begin
        logic [38:0] r;
        logic [6:0]  st;
        int          total;
        int          len;

        // Reset state
        repeat (3) @(posedge aclk);
        #1;
        check("rst_m_tvalid", 64'(m_axis_tvalid), 64'(0));
        check("rst_m_tdata", 64'(m_axis_tdata), 64'(0));
        check("rst_m_tlast", 64'(m_axis_tlast), 64'(0));
        check("rst_m_tuser", 64'(m_axis_tuser), 64'(0));
        check("rst_s_tready", 64'(s_axis_tready), 64'(1));
        check("rst_m0_tvalid", 64'(m0_tvalid), 64'(0));
`ifdef DESCRAMBLER_SEED_OUT_EN
        check("rst_seed_out", 64'(seed_out), 64'(0));
        check("rst_seed_valid", 64'(seed_valid), 64'(0));
`endif
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        // Acquisition: zero payload scrambled from 7'h7F, first beat 32'h40934F70
`ifdef DESCRAMBLER_SEED_OUT_EN
        seed_pulses = 0;
`endif
        pkt = '{32'h0, 32'h0, 32'h0, 32'h0};
        send_pkt(7'h7F, 1'b1);
        idle();
        drain_compare("acq");
`ifdef DESCRAMBLER_SEED_OUT_EN
        check("acq_seed_out", 64'(seed_out), 64'(7'h70));
        check("acq_seed_pulses", 64'(seed_pulses), 64'(1));
`endif

        // Back-to-back packets, second scrambled from 7'h2A (recovered state 7'h5F)
        pkt = '{32'h12345680, 32'hA5A5A5A5, 32'h0F0F0F0F};
        send_pkt(7'h7F, 1'b0);
        pkt = '{32'h76543200, 32'hDEADBEEF, 32'hFFFFFFFF, 32'h00000001};
        send_pkt(7'h2A, 1'b0);
        idle();
        drain_compare("b2b");
`ifdef DESCRAMBLER_SEED_OUT_EN
        check("b2b_seed_out", 64'(seed_out), 64'(7'h5F));
        check("b2b_seed_pulses", 64'(seed_pulses), 64'(3));
`endif

        // Locked seed: recovered state 0, data passes through unchanged
        pkt = '{32'hCAFE0000, 32'h01234567, 32'h89ABCDEF};
        send_pkt(7'h00, 1'b0);
        idle();
        drain_compare("lock");

        // Backpressure: random downstream ready over 100+ beats of mixed packet lengths
        rand_rdy = 1'b1;
        stab_err = 0;
        trdy_err = 0;
        total = 0;
        while (total < 100) begin
            len = $urandom_range(1, 12);
            pkt.delete();
            for (int j = 0; j < len; j++) begin
                pkt.push_back((j == 0) ? ($urandom() & 32'hFFFFFF80) : $urandom());
            end
            send_pkt(7'($urandom_range(1, 127)), 1'b0);
            total += len;
        end
        idle();
        drain_compare("bp");
        rand_rdy = 1'b0;
        check("bp_stable_on_stall", 64'(stab_err), 64'(0));
        check("bp_tready_recovery", 64'(trdy_err), 64'(0));

        // Reset mid-packet with a beat held in the output and one in the skid
        force_rdy = 1'b0;
        st = 7'h2A;
        r = scr(32'h11111100, st);
        st = r[38:32];
        send_beat(r[31:0], 1'b0);
        r = scr(32'h22222222, st);
        send_beat(r[31:0], 1'b0);
        check("mid_skid_full_tready", 64'(s_axis_tready), 64'(0));
        aresetn = 1'b0;
        idle();
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        check("mid_rst_tvalid", 64'(m_axis_tvalid), 64'(0));
        check("mid_rst_tready", 64'(s_axis_tready), 64'(1));
        force_rdy = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        check("mid_no_stale_beats", 64'(got_d.size()), 64'(0));
        pkt = '{32'h0BADF000, 32'hDEADBEEF, 32'h13579BDF, 32'h2468ACE0};
        send_pkt(7'h15, 1'b0);
        idle();
        drain_compare("mid");

        // ACQUIRE=0 instance: keystream restarts from SEED each packet
        d0_beat(32'h40934F70, 1'b0, 32'h0, "a0_b0");
        st = 7'h7F;
        r = scr(32'h0, st);
        st = r[38:32];
        r = scr(32'h0, st);
        st = r[38:32];
        d0_beat(r[31:0], 1'b0, 32'h0, "a0_b1");
        r = scr(32'h0, st);
        d0_beat(r[31:0], 1'b1, 32'h0, "a0_b2");
        r = scr(32'h00000055, 7'h7F);
        d0_beat(r[31:0], 1'b1, 32'h00000055, "a0_noacq");
`ifdef DESCRAMBLER_SEED_OUT_EN
        check("a0_seed_out", 64'(seed_out0), 64'(7'h7F));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
